// File: rtl/qpu_exu_pkg.sv
// Shared widths, info-bus field positions and the buffered execute-result payload
// for the QPU execute stage.
package qpu_exu_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned PC_W       = 32;
  localparam int unsigned RFIDX_W    = 5;
  localparam int unsigned DECINFO_W  = 8;
  localparam int unsigned TIME_W     = 32;
  localparam int unsigned EVENT_W    = 66;
  localparam int unsigned EVENT_NUM  = 8;
  localparam int unsigned OPR_IDX_W  = $clog2(EVENT_NUM);
  localparam int unsigned INFO_GRP_W = 2;

  typedef enum logic [INFO_GRP_W-1:0] {
    GRP_ALU = 2'b00,
    GRP_BJP = 2'b01,
    GRP_QIU = 2'b10,
    GRP_LSU = 2'b11
  } grp_e;

  // ALU group fields
  localparam int unsigned ALU_ADD   = 2;
  localparam int unsigned ALU_XOR   = 3;
  localparam int unsigned ALU_OR    = 4;
  localparam int unsigned ALU_AND   = 5;
  localparam int unsigned ALU_IMM   = 6;
  // BJP group fields
  localparam int unsigned BJP_BEQ   = 2;
  localparam int unsigned BJP_BNE   = 3;
  localparam int unsigned BJP_BLT   = 4;
  localparam int unsigned BJP_BGT   = 5;
  localparam int unsigned BJP_PRDT  = 6;
  // QIU group fields
  localparam int unsigned QIU_QWAIT = 2;
  localparam int unsigned QIU_FMR   = 3;
  localparam int unsigned QIU_SMIS  = 4;
  localparam int unsigned QIU_MEAS  = 5;
  localparam int unsigned QIU_QI    = 6;
  // LSU group fields
  localparam int unsigned LSU_LOAD  = 2;
  localparam int unsigned LSU_STORE = 3;

  typedef struct packed {
    logic [PC_W-1:0]      pc;
    logic [XLEN-1:0]      imm;
    logic                 bjp;
    logic                 bjp_prdt;
    logic                 bjp_rslv;
    logic                 cwb_valid;
    logic [XLEN-1:0]      cwb_data;
    logic [RFIDX_W-1:0]   cwb_rdidx;
    logic                 qcwb_valid;
    logic [XLEN-1:0]      qcwb_data;
    logic [RFIDX_W-1:0]   qcwb_rdidx;
    logic                 twb_valid;
    logic [TIME_W-1:0]    twb_data;
    logic                 ewb_valid;
    logic [EVENT_W-1:0]   ewb_data;
    logic [EVENT_NUM-1:0] ewb_oprand;
  } exu_res_t;

endpackage

// File: rtl/qpu_alu_datapath.sv
// Combinational op/compare unit: turns one dispatched instruction into the full
// commit/write-back payload. Event write-back exists only with QPU_ALU_EVENT_EN.
module qpu_alu_datapath
  import qpu_exu_pkg::*;
(
  input  logic [DECINFO_W-1:0] info,
  input  logic [XLEN-1:0]      rs1,
  input  logic [XLEN-1:0]      rs2,
  input  logic [XLEN-1:0]      imm,
  input  logic [PC_W-1:0]      pc,
  input  logic [RFIDX_W-1:0]   rdidx,
  input  logic                 rdwen,
  input  logic [TIME_W-1:0]    tclk,
  input  logic                 qmr,
  input  logic [EVENT_W-1:0]   edata,
  input  logic [EVENT_NUM-1:0] oprand,
  input  logic                 ntp,
  input  logic                 fmr,
  input  logic                 measure,
  output exu_res_t             res_c,
  output logic                 longpipe_c
);

  grp_e            grp;
  logic [XLEN-1:0] op2;
  logic [XLEN-1:0] alu_val;
  logic [XLEN-1:0] lsu_addr;
  logic            alu_hit;
  logic            bjp_hit;
  logic            bjp_cond;
  logic            rd_nz;
  logic            qwait_f;
  logic            fmr_f;
  logic            meas_f;
  logic            unused_ok;

  assign grp      = grp_e'(info[INFO_GRP_W-1:0]);
  assign rd_nz    = (rdidx != '0);
  assign op2      = info[ALU_IMM] ? imm : rs2;
  assign lsu_addr = rs1 + imm;
  // Side-band dispatch flags only qualify QIU instructions
  assign qwait_f  = info[QIU_QWAIT] | ntp;
  assign fmr_f    = info[QIU_FMR] | fmr;
  assign meas_f   = info[QIU_MEAS] | measure;

  // Lowest set op bit wins should decode ever present more than one
  always_comb begin
    alu_hit = 1'b1;
    alu_val = '0;
    if (info[ALU_ADD])      alu_val = rs1 + op2;
    else if (info[ALU_XOR]) alu_val = rs1 ^ op2;
    else if (info[ALU_OR])  alu_val = rs1 | op2;
    else if (info[ALU_AND]) alu_val = rs1 & op2;
    else                    alu_hit = 1'b0;
  end

  always_comb begin
    bjp_hit  = 1'b1;
    bjp_cond = 1'b0;
    if (info[BJP_BEQ])      bjp_cond = (rs1 == rs2);
    else if (info[BJP_BNE]) bjp_cond = (rs1 != rs2);
    else if (info[BJP_BLT]) bjp_cond = ($signed(rs1) < $signed(rs2));
    else if (info[BJP_BGT]) bjp_cond = ($signed(rs1) > $signed(rs2));
    else                    bjp_hit  = 1'b0;
  end

  always_comb begin
    res_c      = '0;
    longpipe_c = 1'b0;
    res_c.pc   = pc;
    res_c.imm  = imm;
    case (grp)
      GRP_ALU: begin
        res_c.cwb_valid = alu_hit & rdwen & rd_nz;
        res_c.cwb_data  = alu_val;
        res_c.cwb_rdidx = rdidx;
      end
      GRP_BJP: begin
        res_c.bjp      = bjp_hit;
        res_c.bjp_prdt = bjp_hit & info[BJP_PRDT];
        res_c.bjp_rslv = bjp_hit & bjp_cond;
      end
      GRP_QIU: begin
        res_c.twb_valid  = qwait_f;
        res_c.twb_data   = tclk + imm[TIME_W-1:0];
        res_c.cwb_valid  = fmr_f & rd_nz;
        res_c.cwb_data   = XLEN'(qmr);
        res_c.cwb_rdidx  = rdidx;
        res_c.qcwb_valid = info[QIU_SMIS];
        res_c.qcwb_data  = imm;
        res_c.qcwb_rdidx = rdidx;
        longpipe_c       = meas_f;
`ifdef QPU_ALU_EVENT_EN
        res_c.ewb_valid  = meas_f | info[QIU_QI];
        res_c.ewb_data   = {edata[EVENT_W-1:XLEN], imm};
        res_c.ewb_oprand = oprand | (EVENT_NUM'(1) << rdidx[OPR_IDX_W-1:0]);
`endif
      end
      GRP_LSU: begin
        res_c.imm  = lsu_addr;
        longpipe_c = info[LSU_LOAD] | info[LSU_STORE];
      end
      default: ;
    endcase
  end

  // Info bits above the op fields and event inputs in the event-less build go nowhere
  assign unused_ok = ^{info, edata, oprand};

endmodule

// File: rtl/qpu_exu_alu_core.sv
// QPU execute-stage ALU: single-entry output buffer holding commit plus four write-back
// channels until all used channels are accepted. Event channel enabled by QPU_ALU_EVENT_EN.
module qpu_exu_alu_core
  import qpu_exu_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,

  input  logic                 i_valid,
  output logic                 i_ready,
  output logic                 i_longpipe,
  input  logic [XLEN-1:0]      i_rs1,
  input  logic [XLEN-1:0]      i_rs2,
  input  logic [XLEN-1:0]      i_imm,
  input  logic [DECINFO_W-1:0] i_info,
  input  logic [PC_W-1:0]      i_pc,
  input  logic [RFIDX_W-1:0]   i_rdidx,
  input  logic                 i_rdwen,
  input  logic [TIME_W-1:0]    i_clk,
  input  logic                 i_qmr,
  input  logic [EVENT_W-1:0]   i_edata,
  input  logic [EVENT_NUM-1:0] i_oprand,
  input  logic                 i_ntp,
  input  logic                 i_fmr,
  input  logic                 i_measure,

  output logic                 cmt_o_valid,
  input  logic                 cmt_o_ready,
  output logic [PC_W-1:0]      cmt_o_pc,
  output logic [XLEN-1:0]      cmt_o_imm,
  output logic                 cmt_o_bjp,
  output logic                 cmt_o_bjp_prdt,
  output logic                 cmt_o_bjp_rslv,

  output logic                 cwbck_o_valid,
  input  logic                 cwbck_o_ready,
  output logic [XLEN-1:0]      cwbck_o_data,
  output logic [RFIDX_W-1:0]   cwbck_o_rdidx,

  output logic                 qcwbck_o_valid,
  input  logic                 qcwbck_o_ready,
  output logic [XLEN-1:0]      qcwbck_o_data,
  output logic [RFIDX_W-1:0]   qcwbck_o_rdidx,

  output logic                 twbck_o_valid,
  input  logic                 twbck_o_ready,
  output logic [TIME_W-1:0]    twbck_o_data,

  output logic                 ewbck_o_valid,
  input  logic                 ewbck_o_ready,
  output logic [EVENT_W-1:0]   ewbck_o_data,
  output logic [EVENT_NUM-1:0] ewbck_o_oprand
);

  exu_res_t res_c;
  exu_res_t buf_q;
  logic     buf_valid;
  logic     longpipe_c;
  logic     ewb_ok;
  logic     retire;
  logic     accept;

  qpu_alu_datapath u_datapath (
    .info       (i_info),
    .rs1        (i_rs1),
    .rs2        (i_rs2),
    .imm        (i_imm),
    .pc         (i_pc),
    .rdidx      (i_rdidx),
    .rdwen      (i_rdwen),
    .tclk       (i_clk),
    .qmr        (i_qmr),
    .edata      (i_edata),
    .oprand     (i_oprand),
    .ntp        (i_ntp),
    .fmr        (i_fmr),
    .measure    (i_measure),
    .res_c      (res_c),
    .longpipe_c (longpipe_c)
  );

`ifdef QPU_ALU_EVENT_EN
  assign ewb_ok = ~buf_q.ewb_valid | ewbck_o_ready;
`else
  assign ewb_ok = 1'b1;
`endif

  // Retire once every channel the buffered instruction drives is accepted
  assign retire = buf_valid & cmt_o_ready
                & (~buf_q.cwb_valid  | cwbck_o_ready)
                & (~buf_q.qcwb_valid | qcwbck_o_ready)
                & (~buf_q.twb_valid  | twbck_o_ready)
                & ewb_ok;

  assign i_ready    = ~buf_valid | retire;
  assign accept     = i_valid & i_ready;
  assign i_longpipe = i_valid & longpipe_c;

  // Output buffer: a fresh accept overrides retire so back-to-back issue keeps flowing
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_valid <= 1'b0;
      buf_q     <= '0;
    end else if (accept) begin
      buf_valid <= 1'b1;
      buf_q     <= res_c;
    end else if (retire) begin
      buf_valid        <= 1'b0;
      buf_q.cwb_valid  <= 1'b0;
      buf_q.qcwb_valid <= 1'b0;
      buf_q.twb_valid  <= 1'b0;
      buf_q.ewb_valid  <= 1'b0;
    end
  end

  assign cmt_o_valid    = buf_valid;
  assign cmt_o_pc       = buf_q.pc;
  assign cmt_o_imm      = buf_q.imm;
  assign cmt_o_bjp      = buf_q.bjp;
  assign cmt_o_bjp_prdt = buf_q.bjp_prdt;
  assign cmt_o_bjp_rslv = buf_q.bjp_rslv;

  assign cwbck_o_valid  = buf_q.cwb_valid;
  assign cwbck_o_data   = buf_q.cwb_data;
  assign cwbck_o_rdidx  = buf_q.cwb_rdidx;

  assign qcwbck_o_valid = buf_q.qcwb_valid;
  assign qcwbck_o_data  = buf_q.qcwb_data;
  assign qcwbck_o_rdidx = buf_q.qcwb_rdidx;

  assign twbck_o_valid  = buf_q.twb_valid;
  assign twbck_o_data   = buf_q.twb_data;

`ifdef QPU_ALU_EVENT_EN
  assign ewbck_o_valid  = buf_q.ewb_valid;
  assign ewbck_o_data   = buf_q.ewb_data;
  assign ewbck_o_oprand = buf_q.ewb_oprand;
`else
  logic unused_ok;
  assign ewbck_o_valid  = 1'b0;
  assign ewbck_o_data   = '0;
  assign ewbck_o_oprand = '0;
  assign unused_ok      = ^{ewbck_o_ready, buf_q.ewb_valid, buf_q.ewb_data, buf_q.ewb_oprand};
`endif

endmodule

// File: tb/tb_qpu_exu_alu_core.sv
// Directed plus randomized bench for qpu_exu_alu_core against a behavioural model.
`timescale 1ns/1ps
module tb_qpu_exu_alu_core;
  import qpu_exu_pkg::*;

  typedef struct packed {
    logic [31:0] rs1, rs2, imm, pc, tclk;
    logic [7:0]  info;
    logic [4:0]  rd;
    logic        rdwen, qmr, ntp, fmr, meas;
    logic [65:0] edata;
    logic [7:0]  opr;
  } in_t;

  typedef struct packed {
    logic [31:0] pc, cmt_imm;
    logic        bjp, prdt, rslv;
    logic        cwb_v;
    logic [31:0] cwb_d;
    logic [4:0]  cwb_rd;
    logic        qcwb_v;
    logic [31:0] qcwb_d;
    logic [4:0]  qcwb_rd;
    logic        twb_v;
    logic [31:0] twb_d;
    logic        ewb_v;
    logic [65:0] ewb_d;
    logic [7:0]  ewb_opr;
    logic        lp;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic i_valid = 1'b0, i_ready, i_longpipe;
  logic [31:0] i_rs1 = '0, i_rs2 = '0, i_imm = '0, i_pc = '0, tclk = '0;
  logic [7:0]  i_info = '0;
  logic [4:0]  i_rdidx = '0;
  logic        i_rdwen = 1'b0, i_qmr = 1'b0, i_ntp = 1'b0, i_fmr = 1'b0, i_measure = 1'b0;
  logic [65:0] i_edata = '0;
  logic [7:0]  i_oprand = '0;
  logic        cmt_o_valid, cmt_o_ready = 1'b1;
  logic [31:0] cmt_o_pc, cmt_o_imm;
  logic        cmt_o_bjp, cmt_o_bjp_prdt, cmt_o_bjp_rslv;
  logic        cwbck_o_valid, cwbck_o_ready = 1'b1;
  logic [31:0] cwbck_o_data;
  logic [4:0]  cwbck_o_rdidx;
  logic        qcwbck_o_valid, qcwbck_o_ready = 1'b1;
  logic [31:0] qcwbck_o_data;
  logic [4:0]  qcwbck_o_rdidx;
  logic        twbck_o_valid, twbck_o_ready = 1'b1;
  logic [31:0] twbck_o_data;
  logic        ewbck_o_valid, ewbck_o_ready = 1'b1;
  logic [65:0] ewbck_o_data;
  logic [7:0]  ewbck_o_oprand;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  qpu_exu_alu_core dut (
    .clk(clk), .rst_n(rst_n),
    .i_valid(i_valid), .i_ready(i_ready), .i_longpipe(i_longpipe),
    .i_rs1(i_rs1), .i_rs2(i_rs2), .i_imm(i_imm), .i_info(i_info), .i_pc(i_pc),
    .i_rdidx(i_rdidx), .i_rdwen(i_rdwen), .i_clk(tclk), .i_qmr(i_qmr),
    .i_edata(i_edata), .i_oprand(i_oprand), .i_ntp(i_ntp), .i_fmr(i_fmr), .i_measure(i_measure),
    .cmt_o_valid(cmt_o_valid), .cmt_o_ready(cmt_o_ready), .cmt_o_pc(cmt_o_pc), .cmt_o_imm(cmt_o_imm),
    .cmt_o_bjp(cmt_o_bjp), .cmt_o_bjp_prdt(cmt_o_bjp_prdt), .cmt_o_bjp_rslv(cmt_o_bjp_rslv),
    .cwbck_o_valid(cwbck_o_valid), .cwbck_o_ready(cwbck_o_ready),
    .cwbck_o_data(cwbck_o_data), .cwbck_o_rdidx(cwbck_o_rdidx),
    .qcwbck_o_valid(qcwbck_o_valid), .qcwbck_o_ready(qcwbck_o_ready),
    .qcwbck_o_data(qcwbck_o_data), .qcwbck_o_rdidx(qcwbck_o_rdidx),
    .twbck_o_valid(twbck_o_valid), .twbck_o_ready(twbck_o_ready), .twbck_o_data(twbck_o_data),
    .ewbck_o_valid(ewbck_o_valid), .ewbck_o_ready(ewbck_o_ready),
    .ewbck_o_data(ewbck_o_data), .ewbck_o_oprand(ewbck_o_oprand)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference behaviour derived from the instruction-set rules
  function automatic exp_t model(input in_t x);
    exp_t e;
    int a, b;
    logic [31:0] op2;
    e = '0;
    e.pc = x.pc;
    e.cmt_imm = x.imm;
    case (x.info[1:0])
      2'd0: begin
        op2 = x.info[6] ? x.imm : x.rs2;
        e.cwb_rd = x.rd;
        if (x.info[2])      e.cwb_d = 32'(longint'(x.rs1) + longint'(op2));
        else if (x.info[3]) e.cwb_d = x.rs1 ^ op2;
        else if (x.info[4]) e.cwb_d = x.rs1 | op2;
        else if (x.info[5]) e.cwb_d = x.rs1 & op2;
        e.cwb_v = (x.info[5:2] != 0) && x.rdwen && (x.rd != 0);
      end
      2'd1: begin
        a = $signed(x.rs1);
        b = $signed(x.rs2);
        e.bjp = (x.info[5:2] != 0);
        e.prdt = e.bjp && x.info[6];
        if (x.info[2])      e.rslv = (a == b);
        else if (x.info[3]) e.rslv = (a != b);
        else if (x.info[4]) e.rslv = (a < b);
        else if (x.info[5]) e.rslv = (a > b);
      end
      2'd2: begin
        if (x.info[2] || x.ntp) begin
          e.twb_v = 1'b1;
          e.twb_d = 32'(longint'(x.tclk) + longint'(x.imm));
        end
        if ((x.info[3] || x.fmr) && x.rd != 0) begin
          e.cwb_v = 1'b1;
          e.cwb_d = {31'd0, x.qmr};
          e.cwb_rd = x.rd;
        end
        if (x.info[4]) begin
          e.qcwb_v = 1'b1;
          e.qcwb_d = x.imm;
          e.qcwb_rd = x.rd;
        end
        e.lp = x.info[5] || x.meas;
`ifdef QPU_ALU_EVENT_EN
        if (x.info[5] || x.meas || x.info[6]) begin
          e.ewb_v = 1'b1;
          e.ewb_d = {x.edata[65:32], x.imm};
          e.ewb_opr = x.opr | 8'(1 << (x.rd % 8));
        end
`endif
      end
      default: begin
        e.cmt_imm = 32'(longint'(x.rs1) + longint'(x.imm));
        e.lp = x.info[2] || x.info[3];
      end
    endcase
    return e;
  endfunction

  function automatic in_t rand_in();
    in_t x;
    int g, k;
    x = '0;
    x.rs1 = $urandom;
    x.rs2 = ($urandom_range(0, 3) == 0) ? x.rs1 : $urandom;
    x.imm = $urandom;
    x.pc = $urandom;
    x.tclk = $urandom;
    x.rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
    x.rdwen = 1'($urandom);
    x.qmr = 1'($urandom);
    x.edata = {2'($urandom), $urandom, $urandom};
    x.opr = 8'($urandom);
    g = $urandom_range(0, 3);
    x.info[1:0] = 2'(g);
    x.info[7] = 1'($urandom);
    case (g)
      0, 1: begin
        k = $urandom_range(0, 4);
        if (k < 4) x.info[2 + k] = 1'b1;
        x.info[6] = 1'($urandom);
      end
      2: begin
        k = $urandom_range(0, 5);
        if (k < 5) x.info[2 + k] = 1'b1;
        x.ntp = ($urandom_range(0, 3) == 0);
        x.fmr = ($urandom_range(0, 3) == 0);
        x.meas = ($urandom_range(0, 3) == 0);
      end
      default: begin
        k = $urandom_range(0, 2);
        if (k < 2) x.info[2 + k] = 1'b1;
      end
    endcase
    return x;
  endfunction

  task automatic drive(input in_t x);
    i_rs1 = x.rs1; i_rs2 = x.rs2; i_imm = x.imm; i_pc = x.pc; tclk = x.tclk;
    i_info = x.info; i_rdidx = x.rd; i_rdwen = x.rdwen; i_qmr = x.qmr;
    i_ntp = x.ntp; i_fmr = x.fmr; i_measure = x.meas; i_edata = x.edata; i_oprand = x.opr;
  endtask

  task automatic set_ready(input logic c, input logic w, input logic q, input logic t, input logic ev);
    cmt_o_ready = c; cwbck_o_ready = w; qcwbck_o_ready = q; twbck_o_ready = t; ewbck_o_ready = ev;
  endtask

  task automatic check_out(input exp_t e, input string t);
    chk({t, ".cmt_valid"}, 128'(cmt_o_valid), 128'(1));
    chk({t, ".cmt_pc"}, 128'(cmt_o_pc), 128'(e.pc));
    chk({t, ".cmt_imm"}, 128'(cmt_o_imm), 128'(e.cmt_imm));
    chk({t, ".bjp"}, 128'({cmt_o_bjp, cmt_o_bjp_prdt, cmt_o_bjp_rslv}), 128'({e.bjp, e.prdt, e.rslv}));
    chk({t, ".wb_valids"}, 128'({cwbck_o_valid, qcwbck_o_valid, twbck_o_valid, ewbck_o_valid}),
        128'({e.cwb_v, e.qcwb_v, e.twb_v, e.ewb_v}));
    if (e.cwb_v) chk({t, ".cwb"}, 128'({cwbck_o_data, cwbck_o_rdidx}), 128'({e.cwb_d, e.cwb_rd}));
    if (e.qcwb_v) chk({t, ".qcwb"}, 128'({qcwbck_o_data, qcwbck_o_rdidx}), 128'({e.qcwb_d, e.qcwb_rd}));
    if (e.twb_v) chk({t, ".twb"}, 128'(twbck_o_data), 128'(e.twb_d));
    if (e.ewb_v) chk({t, ".ewb"}, 128'({ewbck_o_data, ewbck_o_oprand}), 128'({e.ewb_d, e.ewb_opr}));
  endtask

  task automatic check_idle(input string t);
    chk({t, ".valids"}, 128'({cmt_o_valid, cwbck_o_valid, qcwbck_o_valid, twbck_o_valid, ewbck_o_valid}),
        128'(0));
  endtask

  // One instruction from issue to retire; optional random back-pressure on every channel
  task automatic do_txn(input in_t x, input bit rnd_ready, input string t);
    exp_t e;
    bit done;
    logic exp_ret;
    e = model(x);
    set_ready(1, 1, 1, 1, 1);
    drive(x);
    i_valid = 1'b1;
    #1;
    chk({t, ".i_ready_idle"}, 128'(i_ready), 128'(1));
    chk({t, ".longpipe"}, 128'(i_longpipe), 128'(e.lp));
    @(posedge clk); #1;
    i_valid = 1'b0;
    done = 1'b0;
    for (int c = 0; c < 24 && !done; c++) begin
      if (rnd_ready && c < 16)
        set_ready($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
      else
        set_ready(1, 1, 1, 1, 1);
      #1;
      exp_ret = cmt_o_ready && (!e.cwb_v || cwbck_o_ready) && (!e.qcwb_v || qcwbck_o_ready)
             && (!e.twb_v || twbck_o_ready) && (!e.ewb_v || ewbck_o_ready);
      check_out(e, t);
      chk({t, ".i_ready_busy"}, 128'(i_ready), 128'(exp_ret));
      @(posedge clk); #1;
      done = exp_ret;
    end
    if (!done) chk({t, ".retire_timeout"}, 128'(0), 128'(1));
    check_idle({t, ".drained"});
    set_ready(1, 1, 1, 1, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    in_t x, y;
    exp_t e;

    // Reset state
    #3;
    check_idle("reset");
    chk("reset.data", 128'({cmt_o_pc, cwbck_o_data, twbck_o_data}), 128'(0));
    chk("reset.i_ready", 128'(i_ready), 128'(1));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // ADDI rs1=5 imm=3 rd=2
    x = '0; x.info = 8'h44; x.rs1 = 32'd5; x.imm = 32'd3; x.rd = 5'd2; x.rdwen = 1'b1; x.pc = 32'h40;
    do_txn(x, 1'b0, "addi");

    // BLT -1 < 1, predicted not-taken
    x = '0; x.info = 8'h11; x.rs1 = 32'hFFFF_FFFF; x.rs2 = 32'd1; x.imm = 32'h80; x.pc = 32'h44;
    do_txn(x, 1'b0, "blt");

    // QWAIT clk=6 imm=4
    x = '0; x.info = 8'h06; x.tclk = 32'd6; x.imm = 32'd4; x.pc = 32'h48;
    do_txn(x, 1'b0, "qwait");

    // FMR with classical write-back stalled three cycles
    x = '0; x.info = 8'h0A; x.qmr = 1'b1; x.rd = 5'd3; x.pc = 32'h4C;
    e = model(x);
    drive(x); i_valid = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    set_ready(1, 0, 1, 1, 1);
    for (int c = 0; c < 3; c++) begin
      #1;
      check_out(e, "fmr_stall");
      chk("fmr_stall.i_ready", 128'(i_ready), 128'(0));
      @(posedge clk); #1;
    end
    cwbck_o_ready = 1'b1;
    #1;
    chk("fmr_release.i_ready", 128'(i_ready), 128'(1));
    @(posedge clk); #1;
    check_idle("fmr_retired");

    // Measure oprand=0 rd=1 imm=7
    x = '0; x.info = 8'h22; x.rd = 5'd1; x.imm = 32'd7; x.edata = {2'b10, 32'hA5A5_0F0F, 32'h1234_5678};
    x.pc = 32'h50;
    do_txn(x, 1'b0, "measure");

    // Back-to-back issue while the previous result retires
    x = '0; x.info = 8'h44; x.rs1 = 32'd10; x.imm = 32'd20; x.rd = 5'd4; x.rdwen = 1'b1; x.pc = 32'h100;
    y = '0; y.info = 8'h08; y.rs1 = 32'hF0F0; y.rs2 = 32'h00FF; y.rd = 5'd5; y.rdwen = 1'b1; y.pc = 32'h104;
    drive(x); i_valid = 1'b1;
    @(posedge clk); #1;
    check_out(model(x), "b2b_a");
    drive(y);
    #1;
    chk("b2b.i_ready", 128'(i_ready), 128'(1));
    @(posedge clk); #1;
    i_valid = 1'b0;
    check_out(model(y), "b2b_b");
    @(posedge clk); #1;
    check_idle("b2b_drained");

    // Reset while the buffer is full and stalled
    x = '0; x.info = 8'h44; x.rs1 = 32'd1; x.imm = 32'd1; x.rd = 5'd7; x.rdwen = 1'b1; x.pc = 32'h200;
    drive(x); i_valid = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    set_ready(0, 0, 0, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle("midreset");
    chk("midreset.data", 128'({cmt_o_pc, cwbck_o_data}), 128'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    set_ready(1, 1, 1, 1, 1);
    @(posedge clk); #1;
    check_idle("post_reset");

    // Randomized instructions with random back-pressure
    for (int n = 0; n < 200; n++) begin
      x = rand_in();
      do_txn(x, 1'b1, $sformatf("rnd%0d", n));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
